// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared state enum, coordinate widths and screen geometry
package flappy_pkg;

  localparam int X_W       = 12;
  localparam int Y_W       = 10;
  localparam int SCREEN_W  = 640;
  localparam int PIPE_W    = 52;
  localparam int BIRD_X    = 160;
  localparam int NUM_PIPES = 3;
  localparam int SCORE_MAX = 999;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    OVER
  } state_t;

  // Starting left edge of pipe k, just off the right side of the screen.
  function automatic logic signed [X_W-1:0] home_x(input int k, input int spacing);
    return X_W'(SCREEN_W + k * spacing);
  endfunction

endpackage

// File: rtl/pipe_gap_map.sv
// rtl/pipe_gap_map.sv - maps a 10-bit random value onto a pipe gap top-edge Y
module pipe_gap_map
  import flappy_pkg::*;
#(
  parameter int Y_MIN   = 40,
  parameter int Y_RANGE = 280
) (
  input  logic [9:0]     num,
  output logic [Y_W-1:0] gap_y
);

  logic [19:0] prod;

  // num/1024 scaled into the gap span, so the result never exceeds Y_MIN+Y_RANGE-1.
  assign prod  = 20'(num) * 20'(Y_RANGE);
  assign gap_y = Y_W'(Y_MIN) + prod[19:10];

endmodule

// File: rtl/pipe_spawner.sv
// rtl/pipe_spawner.sv - scrolls, recycles and scores three pipe obstacles
module pipe_spawner
  import flappy_pkg::*;
#(
  parameter int PIPE_SPACING = 240,
  parameter int Y_MIN        = 40,
  parameter int Y_RANGE      = 280,
  parameter int SPEED        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic                  crash,
  input  logic [9:0]            num,
  output logic signed [X_W-1:0] pipe0_x,
  output logic signed [X_W-1:0] pipe1_x,
  output logic signed [X_W-1:0] pipe2_x,
  output logic [Y_W-1:0]        pipe0_y,
  output logic [Y_W-1:0]        pipe1_y,
  output logic [Y_W-1:0]        pipe2_y,
  output logic                  running,
  output logic                  score_pulse,
  output logic [9:0]            score
);

  localparam logic signed [X_W-1:0] SPEED_X = X_W'(SPEED);
  localparam logic signed [X_W-1:0] WRAP_X  = X_W'(NUM_PIPES * PIPE_SPACING);
  localparam logic signed [X_W-1:0] LIMIT_X = X_W'(-PIPE_W);
  localparam logic signed [X_W-1:0] WIDTH_X = X_W'(PIPE_W);
  localparam logic signed [X_W-1:0] BIRD_XS = X_W'(BIRD_X);
  localparam logic [Y_W-1:0]        Y_MID   = Y_W'(Y_MIN + Y_RANGE / 2);
  localparam logic [9:0]            S_MAX   = 10'(SCORE_MAX);

  state_t                state;
  logic [1:0]            load_cnt;
  logic signed [X_W-1:0] px [NUM_PIPES];
  logic [Y_W-1:0]        py [NUM_PIPES];
  logic signed [X_W-1:0] nx [NUM_PIPES];
  logic                  wrap [NUM_PIPES];
  logic                  any_pass;
  logic [Y_W-1:0]        gap;

  pipe_gap_map #(
    .Y_MIN  (Y_MIN),
    .Y_RANGE(Y_RANGE)
  ) u_gap_map (
    .num  (num),
    .gap_y(gap)
  );

  // Recycle and scoring decisions both use the un-wrapped moved position.
  always_comb begin
    any_pass = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      nx[i]   = px[i] - SPEED_X;
      wrap[i] = (nx[i] <= LIMIT_X);
      if ((px[i] + WIDTH_X > BIRD_XS) && (nx[i] + WIDTH_X <= BIRD_XS))
        any_pass = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      load_cnt    <= 2'd0;
      running     <= 1'b0;
      score_pulse <= 1'b0;
      score       <= 10'd0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        px[i] <= home_x(i, PIPE_SPACING);
        py[i] <= Y_MID;
      end
    end else begin
      score_pulse <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state    <= LOAD;
            load_cnt <= 2'd0;
            score    <= 10'd0;
          end
        end
        LOAD: begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (load_cnt == 2'(i)) begin
              px[i] <= home_x(i, PIPE_SPACING);
              py[i] <= gap;
            end
          end
          if (load_cnt == 2'(NUM_PIPES - 1)) begin
            state    <= RUN;
            running  <= 1'b1;
            load_cnt <= 2'd0;
          end else begin
            load_cnt <= load_cnt + 2'd1;
          end
        end
        RUN: begin
          if (crash) begin
            state   <= OVER;
            running <= 1'b0;
          end else if (frame_tick) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
              if (wrap[i]) begin
                px[i] <= nx[i] + WRAP_X;
                py[i] <= gap;
              end else begin
                px[i] <= nx[i];
              end
            end
            if (any_pass) begin
              score_pulse <= 1'b1;
              if (score < S_MAX)
                score <= score + 10'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pipe0_x = px[0];
  assign pipe1_x = px[1];
  assign pipe2_x = px[2];
  assign pipe0_y = py[0];
  assign pipe1_y = py[1];
  assign pipe2_y = py[2];

endmodule

// File: tb/tb_pipe_spawner.sv
// tb/tb_pipe_spawner.sv - randomized directed bench for pipe_spawner against a reference model
module tb_pipe_spawner;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_tick = 1'b0;
  logic               start = 1'b0;
  logic               crash = 1'b0;
  logic [9:0]         num = 10'd0;
  logic signed [11:0] pipe0_x, pipe1_x, pipe2_x;
  logic [9:0]         pipe0_y, pipe1_y, pipe2_y;
  logic               running, score_pulse;
  logic [9:0]         score;

  int errors = 0;
  int checks = 0;

  int mx [3];
  int my [3];
  int mscore;
  int mpulse;
  int mrun;

  pipe_spawner dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .crash      (crash),
    .num        (num),
    .pipe0_x    (pipe0_x),
    .pipe1_x    (pipe1_x),
    .pipe2_x    (pipe2_x),
    .pipe0_y    (pipe0_y),
    .pipe1_y    (pipe1_y),
    .pipe2_y    (pipe2_y),
    .running    (running),
    .score_pulse(score_pulse),
    .score      (score)
  );

  always #5 clk = ~clk;

  function automatic int gap_ref(input int n);
    return 40 + (n * 280) / 1024;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = 640 + 240 * i;
      my[i] = 180;
    end
    mscore = 0;
    mpulse = 0;
    mrun   = 0;
  endtask

  task automatic model_tick(input int n);
    mpulse = 0;
    for (int i = 0; i < 3; i++) begin
      int moved;
      moved = mx[i] - 2;
      if (mx[i] + 52 > 160 && moved + 52 <= 160) mpulse = 1;
      if (moved <= -52) begin
        mx[i] = moved + 720;
        my[i] = gap_ref(n);
      end else begin
        mx[i] = moved;
      end
    end
    if (mpulse == 1 && mscore < 999) mscore++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x0"}, int'(pipe0_x), mx[0]);
    chk({tag, ".x1"}, int'(pipe1_x), mx[1]);
    chk({tag, ".x2"}, int'(pipe2_x), mx[2]);
    chk({tag, ".y0"}, int'(pipe0_y), my[0]);
    chk({tag, ".y1"}, int'(pipe1_y), my[1]);
    chk({tag, ".y2"}, int'(pipe2_y), my[2]);
    chk({tag, ".run"}, int'(running), mrun);
    chk({tag, ".pulse"}, int'(score_pulse), mpulse);
    chk({tag, ".score"}, int'(score), mscore);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n, input string tag);
    num = 10'(n);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (mrun == 1) model_tick(n);
    else mpulse = 0;
    check_all(tag);
  endtask

  task automatic idle_steps(input int k, input string tag);
    for (int j = 0; j < k; j++) begin
      num = 10'($urandom_range(0, 1023));
      step();
      mpulse = 0;
      check_all(tag);
    end
  endtask

  task automatic load_game(input int n0, input int n1, input int n2);
    int ns [3];
    ns[0] = n0; ns[1] = n1; ns[2] = n2;
    start = 1'b1;
    step();
    start = 1'b0;
    mscore = 0;
    mpulse = 0;
    for (int k = 0; k < 3; k++) begin
      num = 10'(ns[k]);
      frame_tick = 1'b1;
      crash = 1'b1;
      step();
      mx[k] = 640 + 240 * k;
      my[k] = gap_ref(ns[k]);
    end
    frame_tick = 1'b0;
    crash = 1'b0;
    mrun = 1;
  endtask

  initial begin
    model_reset();
    step();
    step();
    rst = 1'b0;
    check_all("reset");

    frame_tick = 1'b1;
    crash = 1'b1;
    step();
    frame_tick = 1'b0;
    crash = 1'b0;
    check_all("idle_ignore");

    load_game(0, 512, 1023);
    check_all("load");
    chk("load.y0_const", int'(pipe0_y), 40);
    chk("load.y1_const", int'(pipe1_y), 180);
    chk("load.y2_const", int'(pipe2_y), 319);
    chk("load.running", int'(running), 1);

    for (int t = 1; t <= 346; t++) begin
      int n;
      n = (t == 346) ? 0 : int'($urandom_range(0, 1023));
      do_tick(n, "run");
      if (t == 265) begin
        chk("t265.x0", int'(pipe0_x), 110);
        chk("t265.pulse", int'(score_pulse), 0);
      end
      if (t == 266) begin
        chk("t266.x0", int'(pipe0_x), 108);
        chk("t266.pulse", int'(score_pulse), 1);
        chk("t266.score", int'(score), 1);
      end
      idle_steps(int'($urandom_range(0, 2)), "gap");
    end
    chk("t346.x0", int'(pipe0_x), 668);
    chk("t346.y0", int'(pipe0_y), 40);
    chk("t346.score", int'(score), 1);

    num = 10'($urandom_range(0, 1023));
    frame_tick = 1'b1;
    crash = 1'b1;
    start = 1'b0;
    step();
    frame_tick = 1'b0;
    crash = 1'b0;
    mrun = 0;
    mpulse = 0;
    check_all("crash_tick");

    for (int t = 0; t < 4; t++) begin
      crash = (t == 2);
      do_tick(int'($urandom_range(0, 1023)), "over");
    end
    crash = 1'b0;

    begin
      int a, b, c;
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 1023));
      c = int'($urandom_range(0, 1023));
      load_game(a, b, c);
      check_all("reload");
    end

    for (int t = 0; t < 60; t++)
      do_tick(int'($urandom_range(0, 1023)), "run2");

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    step();
    rst = 1'b0;
    check_all("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_spawner.md
Name: pipe_spawner

Overview:
- Downstream consumer of the random-number stage: takes its 10-bit `num` and turns it into the scrolling pipe obstacles.
- Maintains 3 pipes, each with a horizontal position and a gap top-edge Y.
- Scrolls the pipes left once per frame tick, recycles off-screen pipes to the right with a fresh random gap, and counts score.
- Feeds the collision and VGA draw logic.

Parameters:
SCREEN_W, 640, visible width in pixels
PIPE_W, 52, pipe width in pixels
PIPE_SPACING, 240, X distance between consecutive pipes; 3*PIPE_SPACING >= SCREEN_W+PIPE_W is required
Y_MIN, 40, smallest gap top-edge Y
Y_RANGE, 280, gap Y span; gap_y lies in [Y_MIN, Y_MIN+Y_RANGE-1]
SPEED, 2, pixels moved per frame tick
BIRD_X, 160, bird X position used for scoring

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle pulse: begin a new game
crash  in  1  one-cycle pulse from collision logic
num  in  10  random value from the random-number stage; may change every cycle
pipe0_x, pipe1_x, pipe2_x  out  12 each  signed left-edge X of each pipe
pipe0_y, pipe1_y, pipe2_y  out  10 each  gap top-edge Y of each pipe
running  out  1  high in RUN state
score_pulse  out  1  one-cycle pulse when a pipe passes the bird
score  out  10  pipes passed this game; saturates at 999

Behaviour:
- Reset is asynchronous and active-high; all state is clocked on clk rising edge.
- Reset values:
  - state = IDLE.
  - pipeN_x = SCREEN_W + N*PIPE_SPACING, giving 640, 880, 1120.
  - pipeN_y = Y_MIN + Y_RANGE/2 = 180.
  - running = 0, score_pulse = 0, score = 0.
- Gap mapping: gap = Y_MIN + ((num * Y_RANGE) >> 10).
  - Uses an unsigned 20-bit product.
  - num=0 gives 40; num=1023 gives 319.
- FSM states: IDLE, LOAD, RUN, OVER.
- IDLE:
  - Pipes hold at their reset positions.
  - `start` moves to LOAD.
  - `crash` and `frame_tick` are ignored.
- LOAD (3 cycles, load_cnt 0..2):
  - On cycle k, load pipek_y from the gap mapping of the current `num` and set pipek_x = SCREEN_W + k*PIPE_SPACING.
  - Score clears on entry.
  - After k=2, go to RUN.
  - `start`, `crash` and `frame_tick` are ignored during LOAD.
- RUN:
  - On `frame_tick`, every pipe_x decreases by SPEED, using signed 12-bit arithmetic.
  - Recycle: if a pipe's new x <= -PIPE_W, store new x + 3*PIPE_SPACING instead, and load its y from `num` in the same cycle.
  - Only one pipe can recycle per tick. If this is violated (parameter misuse), recycle each pipe independently.
  - Score: if a pipe's old (x+PIPE_W) > BIRD_X and new (x+PIPE_W) <= BIRD_X, assert score_pulse on the cycle after the tick, and increment score (saturating at 999).
  - Recycling and scoring are evaluated on the pre-recycle new x.
  - `crash` moves to OVER. If `crash` and `frame_tick` coincide, crash wins: no movement, no score.
  - `start` is ignored.
- OVER:
  - Positions, gaps and score freeze.
  - `start` moves to LOAD. `crash` is ignored.
- score_pulse is registered and is never asserted outside RUN-generated updates.
- Reset asserted mid-game returns immediately, asynchronously, to the reset values.

Decomposition:
- Package flappy_pkg holds:
  - the state enum (IDLE/LOAD/RUN/OVER);
  - the coordinate widths (X_W=12, Y_W=10);
  - the shared geometry constants (SCREEN_W, PIPE_W, BIRD_X), also used by the draw and collision blocks.
- Sub-module pipe_gap_map (combinational): num to gap_y via multiply-shift-add. Instantiated once and shared by LOAD and recycle.

Test Plan:
- Reset then release → pipe x = 640/880/1120, all y = 180, score = 0, running = 0. Asserting frame_tick in IDLE leaves everything unchanged.
- start with num forced 0, 512, 1023 on the three LOAD cycles → pipe0_y = 40, pipe1_y = 180, pipe2_y = 319. running = 1 on the 4th cycle.
- In RUN, 266 frame_ticks → pipe0_x = 108, with exactly one score_pulse (the cycle after tick 266) and score = 1. Tick 265 gives no pulse.
- Continue to tick 346 with num = 0 → pipe0_x wraps from -52 to 668 and pipe0_y = 40. No extra score_pulse.
- crash coincident with frame_tick in RUN → positions unchanged and state OVER. Further ticks have no effect. start → LOAD, then score = 0 and x re-initialised.
- Assert rst mid-RUN, between clock edges → outputs take reset values immediately without a clock edge.
